pipe_debug_ctrl: RTL and testbench
==================================

Name: pipe_debug_ctrl

Overview:
- Run/step controller for the 5-stage pipeline latches (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Drives the shared `enableDebug` and `resetDebug` lines of those latches from commands issued by the debug/UART unit.
- Halts the pipeline when the end-of-program marker reaches writeback.
- Counts executed (enabled) cycles for readback by the debug unit.

Parameters:
- CNT_W, 32, width of the executed-cycle counter.
- RST_CYCLES, 2, number of cycles `resetDebug` is held during RESTART (1..15).

Ports:
- clk  in  1  system clock; controller updates on rising edge so outputs are stable before the latches' falling edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe from debug unit.
- cmd_code  in  2  00 STOP, 01 RUN, 10 STEP, 11 RESTART.
- cmd_ready  out  1  controller can accept a command this cycle.
- eop_wb  in  1  eop flag at MEM_WB output (program finished).
- enableDebug  out  1  pipeline latch enable, shared by all stage latches.
- resetDebug  out  1  pipeline latch clear, shared by all stage latches.
- halted  out  1  high in HALT state.
- step_done  out  1  one-cycle pulse when a STEP completes.
- cmd_err  out  1  one-cycle pulse when an accepted command is illegal in the current state.
- cycle_count  out  CNT_W  number of cycles with enableDebug=1 since last reset/RESTART.
- bp_cycle  in  CNT_W  breakpoint cycle value; present only with CYCLE_BREAK_EN.
- bp_hit  out  1  pulse on breakpoint; present only with CYCLE_BREAK_EN.

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, enableDebug=0, resetDebug=0, halted=0, step_done=0, cmd_err=0, cycle_count=0, bp_hit=0.
  - Reset overrides any command or eop_wb in the same cycle.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at posedge.
  - cmd_ready=1 in IDLE, RUN and HALT; cmd_ready=0 in STEP and RESTART. Commands in those states are dropped, not queued.
- All outputs are registered. State transitions take effect one cycle after the accepting edge.
- States:
  - IDLE: enableDebug=0.
    - RUN → RUN.
    - STEP → STEP.
    - RESTART → RESTART.
    - STOP → stay in IDLE, cmd_err pulse.
  - RUN: enableDebug=1 every cycle.
    - STOP → IDLE.
    - RESTART → RESTART.
    - RUN or STEP → cmd_err, stay in RUN.
    - eop_wb=1 → HALT; enableDebug drops the cycle after eop_wb is seen.
  - STEP: enableDebug=1 for exactly one cycle, then → IDLE with step_done=1 in that IDLE entry cycle.
    - If eop_wb=1 during the STEP cycle → HALT instead, step_done still pulses.
  - RESTART: resetDebug=1 and enableDebug=0 for RST_CYCLES cycles (internal 4-bit down-counter), cycle_count cleared on entry, then → IDLE.
  - HALT: enableDebug=0, halted=1.
    - RESTART → RESTART.
    - All other commands → cmd_err, stay in HALT.
- Simultaneous events:
  - In RUN, eop_wb=1 with an accepted STOP in the same cycle → HALT (eop wins).
  - In RUN, eop_wb=1 with an accepted RESTART in the same cycle → RESTART (restart wins).
- cycle_count:
  - Increments by 1 on each posedge where enableDebug=1.
  - Saturates at all-ones, no wrap.
  - Cleared only by reset or RESTART entry.
- The controller never asserts enableDebug and resetDebug in the same cycle.

Optional Feature:
- Macro: CYCLE_BREAK_EN.
- Defined:
  - bp_cycle and bp_hit ports exist.
  - In RUN, when the next count value (cycle_count+1) equals bp_cycle and bp_cycle≠0, the controller → IDLE after that enabled cycle and pulses bp_hit.
  - eop_wb has priority over bp_hit.
  - bp_cycle=0 disables the breakpoint.
- Undefined: ports absent; RUN stops only on STOP, RESTART or eop_wb.

Test Plan:
- Reset then RUN with eop_wb raised at cycle 10 → enableDebug=1 for 11 cycles, HALT, halted=1, cycle_count=11.
- IDLE, STEP ×3 (each issued after cmd_ready returns) → three single-cycle enableDebug pulses, three step_done pulses, cycle_count=3.
- RESTART from HALT with RST_CYCLES=2 → resetDebug=1 for exactly 2 cycles, enableDebug=0, cycle_count=0, then IDLE, halted=0.
- In RUN, STOP and eop_wb in the same cycle → HALT; separately, a RUN command while in RUN → cmd_err pulse, state unchanged.
- reset asserted mid-RESTART and mid-RUN → next cycle all outputs at reset values, state IDLE.
- With CYCLE_BREAK_EN, bp_cycle=5, RUN → 5 enabled cycles, bp_hit pulse, IDLE, cycle_count=5; a subsequent RUN resumes counting.

Source files
------------

// File: rtl/pipe_debug_ctrl_if.sv
// Command channel between the debug/UART unit and the pipeline run/step controller.
// The debug unit is the master; the controller is the slave and returns cmd_ready.
interface pipe_debug_ctrl_if;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_code, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pipe_debug_ctrl.sv
// Run/step controller for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline latches.
// Drives the shared enableDebug/resetDebug latch controls from debug-unit commands,
// halts when the end-of-program marker reaches writeback, and counts enabled cycles.
// Optional macro CYCLE_BREAK_EN adds a cycle-count breakpoint (bp_cycle/bp_hit ports).
// Outputs are registered from the next state, so they settle right after the rising
// edge and are stable before the latches sample on the falling edge.
module pipe_debug_ctrl #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   pipe_debug_ctrl_if.slave cmd,
   input  logic             eop_wb,
   output logic             enableDebug,
   output logic             resetDebug,
   output logic             halted,
   output logic             step_done,
   output logic             cmd_err,
   output logic [CNT_W-1:0] cycle_count
`ifdef CYCLE_BREAK_EN
   ,
   input  logic [CNT_W-1:0] bp_cycle,
   output logic             bp_hit
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STEP,
      RESTART,
      HALT
   } stateT;

   typedef enum logic [1:0] {
      CMD_STOP    = 2'b00,
      CMD_RUN     = 2'b01,
      CMD_STEP    = 2'b10,
      CMD_RESTART = 2'b11
   } cmdT;

   stateT            state;
   stateT            nextState;
   logic             accept;
   cmdT              code;
   logic             errNext;
   logic             bpNext;
   logic [CNT_W-1:0] countInc;
   logic [3:0]       rstCnt;

   // Next-state decision; priority in RUN is RESTART > eop_wb > STOP > breakpoint.
   always_comb begin
      nextState = state;
      errNext   = 1'b0;
      bpNext    = 1'b0;
      accept    = cmd.cmd_valid && cmd.cmd_ready;
      code      = cmdT'(cmd.cmd_code);
      countInc  = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
      case (state)
         IDLE: begin
            if (accept) begin
               case (code)
                  CMD_STOP:    errNext   = 1'b1;
                  CMD_RUN:     nextState = RUN;
                  CMD_STEP:    nextState = STEP;
                  CMD_RESTART: nextState = RESTART;
                  default:     nextState = IDLE;
               endcase
            end
         end
         RUN: begin
            if (accept && (code == CMD_RUN || code == CMD_STEP))
               errNext = 1'b1;
            if (accept && code == CMD_RESTART)
               nextState = RESTART;
            else if (eop_wb)
               nextState = HALT;
            else if (accept && code == CMD_STOP)
               nextState = IDLE;
`ifdef CYCLE_BREAK_EN
            else if (bp_cycle != '0 && countInc == bp_cycle) begin
               nextState = IDLE;
               bpNext    = 1'b1;
            end
`endif
         end
         STEP: begin
            nextState = eop_wb ? HALT : IDLE;
         end
         RESTART: begin
            if (rstCnt <= 4'd1)
               nextState = IDLE;
         end
         HALT: begin
            if (accept) begin
               if (code == CMD_RESTART)
                  nextState = RESTART;
               else
                  errNext = 1'b1;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State, registered outputs, restart down-counter and executed-cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         enableDebug   <= 1'b0;
         resetDebug    <= 1'b0;
         halted        <= 1'b0;
         step_done     <= 1'b0;
         cmd_err       <= 1'b0;
         cmd.cmd_ready <= 1'b1;
         cycle_count   <= '0;
         rstCnt        <= '0;
`ifdef CYCLE_BREAK_EN
         bp_hit        <= 1'b0;
`endif
      end else begin
         state         <= nextState;
         enableDebug   <= (nextState == RUN) || (nextState == STEP);
         resetDebug    <= (nextState == RESTART);
         halted        <= (nextState == HALT);
         cmd.cmd_ready <= (nextState == IDLE) || (nextState == RUN) || (nextState == HALT);
         step_done     <= (state == STEP);
         cmd_err       <= errNext;
`ifdef CYCLE_BREAK_EN
         bp_hit        <= bpNext;
`endif
         // Restart entry clears the count even if the pipeline was enabled this cycle.
         if (nextState == RESTART && state != RESTART) begin
            cycle_count <= '0;
            rstCnt      <= 4'(RST_CYCLES);
         end else begin
            if (enableDebug)
               cycle_count <= countInc;
            if (state == RESTART)
               rstCnt <= rstCnt - 4'd1;
         end
      end
   end

`ifndef CYCLE_BREAK_EN
   logic unusedBp;
   assign unusedBp = bpNext;
`endif

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Directed testbench for pipe_debug_ctrl; counter narrowed to 4 bits to reach saturation.
module tb_pipe_debug_ctrl;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             eop_wb;
   logic             enableDebug;
   logic             resetDebug;
   logic             halted;
   logic             step_done;
   logic             cmd_err;
   logic [CNT_W-1:0] cycle_count;
`ifdef CYCLE_BREAK_EN
   logic [CNT_W-1:0] bp_cycle;
   logic             bp_hit;
`endif

   int unsigned passCount  = 0;
   int unsigned checkCount = 0;

   pipe_debug_ctrl_if ifc ();

   pipe_debug_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (ifc),
      .eop_wb      (eop_wb),
      .enableDebug (enableDebug),
      .resetDebug  (resetDebug),
      .halted      (halted),
      .step_done   (step_done),
      .cmd_err     (cmd_err),
      .cycle_count (cycle_count)
`ifdef CYCLE_BREAK_EN
      ,
      .bp_cycle    (bp_cycle),
      .bp_hit      (bp_hit)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp)
         passCount++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] code);
      ifc.cmd_valid = 1'b1;
      ifc.cmd_code  = code;
      tick();
      ifc.cmd_valid = 1'b0;
   endtask

   initial begin
      int unsigned enCnt;
      int unsigned waitCnt;
      reset         = 1'b1;
      eop_wb        = 1'b0;
      ifc.cmd_valid = 1'b0;
      ifc.cmd_code  = 2'b00;
`ifdef CYCLE_BREAK_EN
      bp_cycle      = '0;
`endif
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkVal("rstEnable", enableDebug, 0);
      checkVal("rstResetDbg", resetDebug, 0);
      checkVal("rstHalted", halted, 0);
      checkVal("rstReady", ifc.cmd_ready, 1);
      checkVal("rstCount", cycle_count, 0);
      checkVal("rstStepDone", step_done, 0);
      checkVal("rstErr", cmd_err, 0);

      // RUN with eop_wb on the 11th enabled cycle
      issue(2'b01);
      enCnt = 0;
      for (int i = 0; i <= 10; i++) begin
         eop_wb = (i == 10);
         if (enableDebug) enCnt++;
         tick();
      end
      eop_wb = 1'b0;
      checkVal("runEnCycles", enCnt, 11);
      checkVal("haltEnable", enableDebug, 0);
      checkVal("haltHalted", halted, 1);
      checkVal("haltCount", cycle_count, 11);

      // Illegal RUN in HALT
      issue(2'b01);
      checkVal("haltErr", cmd_err, 1);
      checkVal("haltStay", halted, 1);
      tick();
      checkVal("haltErrPulse", cmd_err, 0);

      // RESTART from HALT, with a command dropped while not ready
      issue(2'b11);
      checkVal("rs0Reset", resetDebug, 1);
      checkVal("rs0Enable", enableDebug, 0);
      checkVal("rs0Count", cycle_count, 0);
      checkVal("rs0Halted", halted, 0);
      checkVal("rs0Ready", ifc.cmd_ready, 0);
      issue(2'b01);
      checkVal("rs1Reset", resetDebug, 1);
      tick();
      checkVal("rs2Reset", resetDebug, 0);
      checkVal("rs2Enable", enableDebug, 0);
      checkVal("rs2Ready", ifc.cmd_ready, 1);
      tick();
      checkVal("rsDroppedCmd", enableDebug, 0);

      // Three STEPs, each once cmd_ready is back
      for (int k = 0; k < 3; k++) begin
         waitCnt = 0;
         while (!ifc.cmd_ready && waitCnt < 10) begin
            tick();
            waitCnt++;
         end
         checkVal("stepReadyWait", ifc.cmd_ready, 1);
         issue(2'b10);
         checkVal("stepEnable", enableDebug, 1);
         checkVal("stepReady", ifc.cmd_ready, 0);
         tick();
         checkVal("stepEnableOff", enableDebug, 0);
         checkVal("stepDone", step_done, 1);
         checkVal("stepCount", cycle_count, k + 1);
         tick();
         checkVal("stepDonePulse", step_done, 0);
      end
      checkVal("stepTotal", cycle_count, 3);

      // STOP in IDLE is illegal
      issue(2'b00);
      checkVal("idleStopErr", cmd_err, 1);
      checkVal("idleStopEn", enableDebug, 0);

      // RUN, illegal RUN while running, then STOP together with eop_wb
      issue(2'b01);
      checkVal("run2Enable", enableDebug, 1);
      issue(2'b01);
      checkVal("runRunErr", cmd_err, 1);
      checkVal("runRunStay", enableDebug, 1);
      checkVal("runRunCount", cycle_count, 4);
      tick();
      eop_wb = 1'b1;
      issue(2'b00);
      eop_wb = 1'b0;
      checkVal("stopEopHalt", halted, 1);
      checkVal("stopEopEn", enableDebug, 0);
      checkVal("stopEopCount", cycle_count, 6);

      // Reset mid-RUN
      issue(2'b11);
      tick();
      tick();
      issue(2'b01);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkVal("midRunEn", enableDebug, 0);
      checkVal("midRunCount", cycle_count, 0);
      checkVal("midRunReady", ifc.cmd_ready, 1);

      // Reset mid-RESTART
      issue(2'b11);
      checkVal("preRstRd", resetDebug, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkVal("midRsRd", resetDebug, 0);
      checkVal("midRsEn", enableDebug, 0);
      checkVal("midRsHalted", halted, 0);

      // RESTART wins over eop_wb in RUN
      issue(2'b01);
      tick();
      eop_wb = 1'b1;
      issue(2'b11);
      eop_wb = 1'b0;
      checkVal("rsEopRd", resetDebug, 1);
      checkVal("rsEopHalted", halted, 0);
      checkVal("rsEopCount", cycle_count, 0);
      tick();
      tick();
      checkVal("rsEopIdle", resetDebug, 0);

`ifdef CYCLE_BREAK_EN
      // Breakpoint at 5, then resume
      bp_cycle = 4'd5;
      issue(2'b01);
      enCnt = 0;
      waitCnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (!enableDebug) break;
         enCnt++;
         tick();
         if (bp_hit) waitCnt++;
      end
      checkVal("bpEnCycles", enCnt, 5);
      checkVal("bpHit", waitCnt, 1);
      checkVal("bpCount", cycle_count, 5);
      checkVal("bpIdle", enableDebug, 0);
      issue(2'b01);
      tick();
      checkVal("bpResume", cycle_count, 6);
      bp_cycle = '0;
      issue(2'b00);
      issue(2'b11);
      tick();
      tick();
`endif

      // Saturation of the narrowed counter
      issue(2'b01);
      for (int i = 0; i < 20; i++) tick();
      checkVal("satCount", cycle_count, 15);
      checkVal("satStillRun", enableDebug, 1);
      issue(2'b00);
      checkVal("satStop", enableDebug, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
